memory_playback_ctrl: RTL and testbench
=======================================

// Module: memory_playback_ctrl
// PURPOSE
//  Reader side of the song memory: selects a stored song unit, rewinds it, fetches entries
//  one by one via read_en/output_ready and drives the note to the tone generator for a fixed slot.
//  Sits between the mode FSM (start/stop/pause, song choice) and the memory block / buzzer path.
// PARAMETERS
//  DATA_WIDTH   8           width of one stored note entry (0 = rest)
//  SEL_WIDTH    4           width of unit select (matches memory select port)
//  NUM_UNITS    9           number of memory units; song_sel >= NUM_UNITS is rejected
//  DEPTH_WIDTH  8           width of per-unit entry count (duration)
//  SLOT_CYCLES  25_000_000  clk cycles each entry is held (0.25 s at 100 MHz)
//  WAIT_LIMIT   16          max cycles to wait for output_ready after a fetch
// PORTS
//  clk              in   1            system clock
//  rst              in   1            synchronous, active-high reset
//  start            in   1            1-cycle pulse: begin playing song_sel
//  stop             in   1            level/pulse: abort playback
//  pause            in   1            level: freeze playback while high
//  song_sel         in   SEL_WIDTH    unit to play, latched on accepted start
//  mem_unit_status  in   NUM_UNITS    occupancy bitmap from memory
//  mem_duration     in   DEPTH_WIDTH  entry count of selected unit
//  mem_data         in   DATA_WIDTH   entry at current read pointer
//  mem_output_ready in   1            mem_data valid
//  mem_select       out  SEL_WIDTH    unit select to memory
//  mem_read_en      out  1            1-cycle pulse: advance read pointer
//  mem_read_rst     out  1            1-cycle pulse: rewind read pointer
//  note_out         out  DATA_WIDTH   note to tone generator (0 = silence)
//  playing          out  1            high in any non-IDLE state
//  done             out  1            1-cycle pulse at end/abort of a song
//  err              out  1            sticky: empty/invalid unit or ready timeout; cleared by next accepted start
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, mem_select 0.
//  States: IDLE -> REWIND -> FETCH -> WAIT -> PLAY -> (FETCH | FINISH); PAUSED; FINISH -> IDLE.
//  IDLE: start accepted only here; latch song_sel into mem_select. If song_sel>=NUM_UNITS or
//    mem_unit_status[song_sel]==0: set err, go FINISH. Else clear err, go REWIND.
//  REWIND: mem_read_rst=1 for exactly 1 cycle; idx<=0; next FETCH.
//  FETCH: if idx==mem_duration (incl. duration 0) go FINISH; else mem_read_en=1 for 1 cycle, go WAIT.
//  WAIT: on mem_output_ready, register mem_data into note_out, slot counter<=0, go PLAY.
//    Timeout after WAIT_LIMIT cycles: set err, go FINISH.
//  PLAY: hold note_out; count to SLOT_CYCLES-1, then idx<=idx+1, go FETCH. Entry latency:
//    note_out changes 1 cycle after output_ready seen; each entry held exactly SLOT_CYCLES cycles.
//  PAUSED: entered from WAIT/PLAY while pause=1; note_out forced 0, counters frozen;
//    on pause=0 return to saved state and restore held note.
//  FINISH: note_out<=0, done=1 for 1 cycle, go IDLE.
//  stop has priority over pause and all states except IDLE: next cycle FINISH (done still pulses).
//  start while not IDLE is ignored; start and stop in same IDLE cycle: stop wins, nothing happens.
//  mem_select remains stable during playback (memory output mux must not glitch mid-song).
//  idx width DEPTH_WIDTH+1 so idx==2**DEPTH_WIDTH-1 comparison never wraps.
//  Reset mid-playback: next cycle IDLE, note_out 0, no done pulse, err cleared.
// STRUCTURE
//  Shared header (alongside memory params): DATA_WIDTH, SEL/DEPTH widths, unit count, state
//  encodings, NOTE_REST=0. One sub-module: slot_timer (load/enable/freeze counter, 'expired'
//  flag) used for SLOT_CYCLES and reused for WAIT_LIMIT timeout. Rest is one FSM + registers.
// TESTING (SLOT_CYCLES=4, WAIT_LIMIT=3, memory model with 1-cycle ready)
//  1. Unit 2 holds {5,7,9}, status bit set, start sel=2 -> read_rst once, note_out 5,7,9 each 4 cycles, then 0, done 1 pulse.
//  2. start sel=6 with status[6]=0 -> no read_rst/read_en, err=1, done pulse 1 cycle later.
//  3. Playing entry 7, pause high 10 cycles -> note_out 0 during pause, resumes 7 for remaining cycles; total 4 active.
//  4. stop during second entry -> next cycle FINISH, note_out 0, done pulse, no further read_en.
//  5. Memory never raises ready -> err=1 after 3 WAIT cycles, done pulse, playing drops.
//  6. rst asserted mid-PLAY -> next cycle all outputs 0, no done; fresh start plays from entry 0.

Source files
------------

// File: rtl/memory_playback_ctrl_pkg.sv
// rtl/memory_playback_ctrl_pkg.sv - shared widths, unit count and FSM encoding for song playback
package memory_playback_ctrl_pkg;
    localparam int DATA_WIDTH  = 8;
    localparam int SEL_WIDTH   = 4;
    localparam int NUM_UNITS   = 9;
    localparam int DEPTH_WIDTH = 8;

    localparam logic [DATA_WIDTH-1:0] NOTE_REST = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REWIND,
        ST_FETCH,
        ST_WAIT,
        ST_PLAY,
        ST_PAUSED,
        ST_FINISH
    } state_t;
endpackage

// File: rtl/memory_playback_ctrl_if.sv
// rtl/memory_playback_ctrl_if.sv - song memory read bus between playback controller and memory
interface memory_playback_ctrl_if
    import memory_playback_ctrl_pkg::*;
;
    logic [SEL_WIDTH-1:0]   select;
    logic                   read_en;
    logic                   read_rst;
    logic [NUM_UNITS-1:0]   unit_status;
    logic [DEPTH_WIDTH-1:0] duration;
    logic [DATA_WIDTH-1:0]  data;
    logic                   output_ready;

    modport master (
        output select, read_en, read_rst,
        input  unit_status, duration, data, output_ready
    );

    modport slave (
        input  select, read_en, read_rst,
        output unit_status, duration, data, output_ready
    );
endinterface

// File: rtl/memory_playback_ctrl_slot_timer.sv
// rtl/memory_playback_ctrl_slot_timer.sv - loadable cycle counter with saturating expired flag
module memory_playback_ctrl_slot_timer #(
    parameter int LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);
    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] r_count;

    // Counter stops at LIMIT-1 so a late consumer still sees expired.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_load) begin
            r_count <= '0;
        end else if (i_en && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == W'(LIMIT - 1));
endmodule

// File: rtl/memory_playback_ctrl.sv
// rtl/memory_playback_ctrl.sv - reads a song unit entry by entry and drives notes for fixed slots
module memory_playback_ctrl
    import memory_playback_ctrl_pkg::*;
#(
    parameter int SLOT_CYCLES = 25_000_000,
    parameter int WAIT_LIMIT  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_pause,
    input  logic [SEL_WIDTH-1:0]  i_song_sel,
    memory_playback_ctrl_if.master mem_if,
    output logic [DATA_WIDTH-1:0] o_note_out,
    output logic                  o_playing,
    output logic                  o_done,
    output logic                  o_err
);
    state_t                 r_state, r_ret_state, w_next;
    logic [SEL_WIDTH-1:0]   r_sel;
    logic [DEPTH_WIDTH:0]   r_idx;
    logic [DATA_WIDTH-1:0]  r_note;
    logic                   r_err;

    logic w_read_en, w_read_rst, w_accept, w_set_err;
    logic w_idx_clr, w_idx_inc, w_note_load, w_abort;
    logic w_slot_load, w_slot_en, w_slot_expired;
    logic w_wait_load, w_wait_en, w_wait_expired;
    logic w_unit_valid;

    assign w_unit_valid = (i_song_sel < SEL_WIDTH'(NUM_UNITS)) && mem_if.unit_status[i_song_sel];
    assign w_abort      = i_stop && (r_state != ST_IDLE) && (r_state != ST_FINISH);

    memory_playback_ctrl_slot_timer #(.LIMIT(SLOT_CYCLES)) u_slot_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (w_slot_load),
        .i_en      (w_slot_en),
        .o_expired (w_slot_expired)
    );

    memory_playback_ctrl_slot_timer #(.LIMIT(WAIT_LIMIT)) u_wait_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (w_wait_load),
        .i_en      (w_wait_en),
        .o_expired (w_wait_expired)
    );

    always_comb begin
        w_next      = r_state;
        w_read_en   = 1'b0;
        w_read_rst  = 1'b0;
        w_accept    = 1'b0;
        w_set_err   = 1'b0;
        w_idx_clr   = 1'b0;
        w_idx_inc   = 1'b0;
        w_note_load = 1'b0;
        w_slot_load = 1'b0;
        w_slot_en   = 1'b0;
        w_wait_load = 1'b0;
        w_wait_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    w_accept = 1'b1;
                    if (w_unit_valid) begin
                        w_next = ST_REWIND;
                    end else begin
                        w_set_err = 1'b1;
                        w_next    = ST_FINISH;
                    end
                end
            end
            ST_REWIND: begin
                w_read_rst = 1'b1;
                w_idx_clr  = 1'b1;
                w_next     = ST_FETCH;
            end
            ST_FETCH: begin
                if (r_idx == {1'b0, mem_if.duration}) begin
                    w_next = ST_FINISH;
                end else begin
                    w_read_en   = 1'b1;
                    w_wait_load = 1'b1;
                    w_next      = ST_WAIT;
                end
            end
            // A ready pulse is never dropped in favour of pause.
            ST_WAIT: begin
                w_wait_en = 1'b1;
                if (mem_if.output_ready) begin
                    w_note_load = 1'b1;
                    w_slot_load = 1'b1;
                    w_next      = ST_PLAY;
                end else if (i_pause) begin
                    w_next = ST_PAUSED;
                end else if (w_wait_expired) begin
                    w_set_err = 1'b1;
                    w_next    = ST_FINISH;
                end
            end
            ST_PLAY: begin
                w_slot_en = 1'b1;
                if (w_slot_expired) begin
                    w_idx_inc = 1'b1;
                    w_next    = ST_FETCH;
                end else if (i_pause) begin
                    w_next = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (!i_pause) begin
                    w_next = r_ret_state;
                end
            end
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
        if (w_abort) begin
            w_next      = ST_FINISH;
            w_read_en   = 1'b0;
            w_set_err   = 1'b0;
            w_idx_inc   = 1'b0;
            w_note_load = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_ret_state <= ST_IDLE;
            r_sel       <= '0;
            r_idx       <= '0;
            r_note      <= NOTE_REST;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == ST_PAUSED && r_state != ST_PAUSED) begin
                r_ret_state <= r_state;
            end
            if (w_accept) begin
                r_sel <= i_song_sel;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end else if (w_accept) begin
                r_err <= 1'b0;
            end
            if (w_idx_clr) begin
                r_idx <= '0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + 1'b1;
            end
            if (w_note_load) begin
                r_note <= mem_if.data;
            end
        end
    end

    // Only PLAY sounds the note: pause, fetch gaps and finish are silent.
    assign o_note_out      = (r_state == ST_PLAY) ? r_note : NOTE_REST;
    assign o_playing       = (r_state != ST_IDLE);
    assign o_done          = (r_state == ST_FINISH);
    assign o_err           = r_err;
    assign mem_if.select   = r_sel;
    assign mem_if.read_en  = w_read_en;
    assign mem_if.read_rst = w_read_rst;
endmodule

// File: tb/tb_memory_playback_ctrl.sv
// tb/tb_memory_playback_ctrl.sv - directed bench for memory_playback_ctrl with a 1-cycle memory model
module tb_memory_playback_ctrl;
    import memory_playback_ctrl_pkg::*;

    logic                  i_clk = 1'b0;
    logic                  i_rst = 1'b1;
    logic                  i_start = 1'b0;
    logic                  i_stop = 1'b0;
    logic                  i_pause = 1'b0;
    logic [SEL_WIDTH-1:0]  i_song_sel = '0;
    logic [DATA_WIDTH-1:0] o_note_out;
    logic                  o_playing, o_done, o_err;

    memory_playback_ctrl_if mem_if();

    memory_playback_ctrl #(.SLOT_CYCLES(4), .WAIT_LIMIT(3)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_stop     (i_stop),
        .i_pause    (i_pause),
        .i_song_sel (i_song_sel),
        .mem_if     (mem_if),
        .o_note_out (o_note_out),
        .o_playing  (o_playing),
        .o_done     (o_done),
        .o_err      (o_err)
    );

    always #5 i_clk = ~i_clk;

    logic [7:0] m_tbl [0:8][0:3];
    logic [7:0] m_dur [0:8];
    int         m_ptr;
    logic [7:0] m_rd;
    logic       m_ready;
    logic       ready_ok = 1'b1;

    assign mem_if.unit_status  = 9'b0_0000_0101;
    assign mem_if.duration     = (mem_if.select < 4'd9) ? m_dur[mem_if.select] : 8'd0;
    assign mem_if.data         = m_rd;
    assign mem_if.output_ready = m_ready;

    always @(posedge i_clk) begin
        if (i_rst) begin
            m_ptr   <= 0;
            m_ready <= 1'b0;
            m_rd    <= 8'd0;
        end else begin
            m_ready <= mem_if.read_en && ready_ok;
            if (mem_if.read_rst) begin
                m_ptr <= 0;
            end else if (mem_if.read_en) begin
                if (mem_if.select < 4'd9 && m_ptr < 4) m_rd <= m_tbl[mem_if.select][m_ptr];
                m_ptr <= m_ptr + 1;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] t_note [0:39];
    logic [3:0] t_sel  [0:39];
    logic       t_done [0:39];
    logic       t_rden [0:39];
    logic       t_rrst [0:39];
    logic       t_err  [0:39];
    logic       t_play [0:39];

    int exp1 [22] = '{0,0,0,5,5,5,5,0,0,7,7,7,7,0,0,9,9,9,9,0,0,0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic play(input logic [3:0] sel, input int n, input int pon, input int poff,
                        input int stop_at, input int start_at, input int rst_at);
        @(negedge i_clk);
        i_start    = 1'b1;
        i_song_sel = sel;
        for (int k = 0; k < n; k++) begin
            @(negedge i_clk);
            t_note[k] = o_note_out;
            t_sel[k]  = mem_if.select;
            t_done[k] = o_done;
            t_rden[k] = mem_if.read_en;
            t_rrst[k] = mem_if.read_rst;
            t_err[k]  = o_err;
            t_play[k] = o_playing;
            i_start = (k == start_at);
            if (k == start_at) i_song_sel = 4'd3;
            i_pause = (k >= pon && k < poff);
            i_stop  = (k == stop_at);
            i_rst   = (k == rst_at);
        end
        i_start = 1'b0;
        i_pause = 1'b0;
        i_stop  = 1'b0;
        i_rst   = 1'b0;
    endtask

    function automatic int cnt(input int which, input int n);
        int c = 0;
        for (int k = 0; k < n; k++) begin
            case (which)
                0: c += int'(t_done[k]);
                1: c += int'(t_rden[k]);
                default: c += int'(t_rrst[k]);
            endcase
        end
        return c;
    endfunction

    function automatic int cnt_note(input logic [7:0] v, input int n);
        int c = 0;
        for (int k = 0; k < n; k++) if (t_note[k] == v) c++;
        return c;
    endfunction

    function automatic int first_done(input int n);
        for (int k = 0; k < n; k++) if (t_done[k]) return k;
        return -1;
    endfunction

    initial begin
        for (int u = 0; u < 9; u++) begin
            m_dur[u] = 8'd0;
            for (int e = 0; e < 4; e++) m_tbl[u][e] = 8'd0;
        end
        m_dur[2] = 8'd3;
        m_tbl[2][0] = 8'd5;
        m_tbl[2][1] = 8'd7;
        m_tbl[2][2] = 8'd9;

        repeat (3) @(negedge i_clk);
        check("rst_playing", o_playing, 0);
        check("rst_done", o_done, 0);
        check("rst_err", o_err, 0);
        check("rst_note", o_note_out, 0);
        check("rst_select", mem_if.select, 0);
        check("rst_read_en", mem_if.read_en, 0);
        check("rst_read_rst", mem_if.read_rst, 0);
        i_rst = 1'b0;

        // Song 5,7,9 with a start pulse mid-song that must be ignored.
        play(4'd2, 22, -1, -1, -1, 5, -1);
        for (int k = 0; k < 22; k++) check($sformatf("t1_note_%0d", k), t_note[k], exp1[k]);
        check("t1_read_rst_cnt", cnt(2, 22), 1);
        check("t1_read_rst_first", t_rrst[0], 1);
        check("t1_read_en_cnt", cnt(1, 22), 3);
        check("t1_done_cnt", cnt(0, 22), 1);
        check("t1_done_at", first_done(22), 20);
        check("t1_playing_end", t_play[21], 0);
        begin
            int bad = 0;
            for (int k = 0; k < 21; k++) if (t_sel[k] != 4'd2) bad++;
            check("t1_select_stable", bad, 0);
        end

        play(4'd6, 4, -1, -1, -1, -1, -1);
        check("t2_done_at", first_done(4), 0);
        check("t2_err", t_err[1], 1);
        check("t2_read_rst_cnt", cnt(2, 4), 0);
        check("t2_read_en_cnt", cnt(1, 4), 0);
        check("t2_playing_end", t_play[1], 0);

        play(4'd2, 32, 10, 20, -1, -1, -1);
        check("t3_err_cleared", t_err[0], 0);
        check("t3_note5_cnt", cnt_note(8'd5, 32), 4);
        check("t3_note7_cnt", cnt_note(8'd7, 32), 4);
        check("t3_note9_cnt", cnt_note(8'd9, 32), 4);
        check("t3_pause_first", t_note[11], 0);
        check("t3_pause_last", t_note[20], 0);
        check("t3_resume", t_note[21], 7);
        check("t3_playing_paused", t_play[15], 1);
        check("t3_done_at", first_done(32), 30);

        play(4'd2, 14, -1, -1, 10, -1, -1);
        check("t4_done_at", first_done(14), 11);
        check("t4_note_stop", t_note[11], 0);
        check("t4_read_en_cnt", cnt(1, 14), 2);
        check("t4_note7_cnt", cnt_note(8'd7, 14), 2);
        check("t4_playing_end", t_play[12], 0);

        ready_ok = 1'b0;
        play(4'd2, 8, -1, -1, -1, -1, -1);
        check("t5_err_before", t_err[4], 0);
        check("t5_err_after", t_err[5], 1);
        check("t5_done_at", first_done(8), 5);
        check("t5_read_en_cnt", cnt(1, 8), 1);
        check("t5_playing_end", t_play[6], 0);
        ready_ok = 1'b1;

        play(4'd2, 10, -1, -1, -1, -1, 5);
        check("t6_note_before", t_note[5], 5);
        check("t6_note_after", t_note[6], 0);
        check("t6_playing_after", t_play[6], 0);
        check("t6_err_after", t_err[6], 0);
        check("t6_done_cnt", cnt(0, 10), 0);
        play(4'd2, 8, -1, -1, -1, -1, -1);
        check("t6_restart_rewind", t_rrst[0], 1);
        check("t6_restart_note", t_note[3], 5);
        repeat (20) @(negedge i_clk);

        @(negedge i_clk);
        i_start    = 1'b1;
        i_stop     = 1'b1;
        i_song_sel = 4'd2;
        @(negedge i_clk);
        i_start = 1'b0;
        i_stop  = 1'b0;
        check("t7_playing", o_playing, 0);
        check("t7_read_rst", mem_if.read_rst, 0);
        @(negedge i_clk);
        check("t7_done", o_done, 0);

        play(4'd0, 4, -1, -1, -1, -1, -1);
        check("t8_read_rst", t_rrst[0], 1);
        check("t8_read_en_cnt", cnt(1, 4), 0);
        check("t8_done_at", first_done(4), 2);
        check("t8_err", t_err[2], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
